// File: rtl/parallel_accum_pkg.sv
// -----------------------------------------------------------------------------
// parallel_accum_pkg
//   Shared definitions for the parallel accumulator datapath: default lane
//   count and word width, derived index/count widths, and the lane vector
//   type used between the packer and the PAR_FACTOR-lane accumulator.
// -----------------------------------------------------------------------------
package parallel_accum_pkg;

  localparam int DEF_PAR_FACTOR = 4;
  localparam int DEF_DATA_WIDTH = 4;

  // Width of a lane index 0..p-1 (at least one bit).
  function automatic int lane_idx_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  // Width of a lane count 0..p.
  function automatic int lane_cnt_w(input int p);
    return $clog2(p + 1);
  endfunction

  localparam int LANE_IDX_W = lane_idx_w(DEF_PAR_FACTOR);
  localparam int LANE_CNT_W = lane_cnt_w(DEF_PAR_FACTOR);

  typedef logic [DEF_DATA_WIDTH-1:0] lane_vec_t [DEF_PAR_FACTOR];

endpackage

// File: rtl/parallel_lane_packer.sv
// -----------------------------------------------------------------------------
// parallel_lane_packer
//   Serial-to-parallel front end: accepts one DATA_WIDTH word per cycle on a
//   valid/ready stream and packs PAR_FACTOR consecutive words (lane 0 first)
//   into one lane vector presented on a valid/ready output. Full throughput of
//   one word per cycle when the output is not back-pressured.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   s_data   input word
//   s_valid  input word valid
//   s_ready  packer can accept s_data this cycle
//   m_data   lane vector; m_data[i] is the i-th word of the group
//   m_valid  m_data valid
//   m_ready  consumer accepts m_data
//   m_count  number of real lanes in m_data
//   flush    (only with PARALLEL_LANE_PACKER_FLUSH_EN) emit a partial group
//
// Optional feature macro: PARALLEL_LANE_PACKER_FLUSH_EN
//   When defined, a flush input emits the staged partial group padded with
//   zeros, with m_count giving the number of real lanes. When undefined the
//   packer only ever emits full groups.
// -----------------------------------------------------------------------------
module parallel_lane_packer
  import parallel_accum_pkg::*;
#(
  parameter int PAR_FACTOR = DEF_PAR_FACTOR,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         m_data [PAR_FACTOR],
  output logic                          m_valid,
  input  logic                          m_ready,
`ifdef PARALLEL_LANE_PACKER_FLUSH_EN
  input  logic                          flush,
`endif
  output logic [$clog2(PAR_FACTOR+1)-1:0] m_count
);

  localparam int IDX_W = lane_idx_w(PAR_FACTOR);
  localparam int CNT_W = $clog2(PAR_FACTOR + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_FACTOR - 1);

  // Lanes 0..P-2 are staged; the final lane goes straight from s_data into
  // the output register on completion, so it never needs a staging slot.
  logic [DATA_WIDTH-1:0] stage [PAR_FACTOR-1];
  logic [IDX_W-1:0]      idx;

  logic last;
  logic out_free;
  logic in_acc;
  logic flush_fire;

  assign last     = (idx == LAST_IDX);
  assign out_free = !m_valid || m_ready;

`ifdef PARALLEL_LANE_PACKER_FLUSH_EN
  // Flush takes priority over input: s_ready is dropped while a flush fires,
  // so an input accept and a flush can never coincide and s_ready stays
  // independent of s_valid.
  assign flush_fire = flush && (idx != '0) && out_free;
`else
  assign flush_fire = 1'b0;
`endif

  // Stall only when completing a group while the previous vector is held.
  always_comb begin
    s_ready = (!last || out_free) && !flush_fire;
  end

  assign in_acc = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      m_valid <= 1'b0;
      m_count <= '0;
      for (int i = 0; i < PAR_FACTOR - 1; i++) stage[i] <= '0;
      for (int i = 0; i < PAR_FACTOR; i++) m_data[i] <= '0;
    end else begin
      // ---- staging / fill index ----
      if (in_acc) begin
        idx <= last ? '0 : idx + IDX_W'(1);
        for (int i = 0; i < PAR_FACTOR - 1; i++) begin
          if (!last && idx == IDX_W'(i)) stage[i] <= s_data;
        end
      end else if (flush_fire) begin
        idx <= '0;
      end

      // ---- output register: load full group, load partial, or drain ----
      if (in_acc && last) begin
        for (int i = 0; i < PAR_FACTOR - 1; i++) m_data[i] <= stage[i];
        m_data[PAR_FACTOR-1] <= s_data;
        m_count <= CNT_W'(PAR_FACTOR);
        m_valid <= 1'b1;
      end else if (flush_fire) begin
        // Lane P-1 is always padding: a partial group has at most P-1 words.
        for (int i = 0; i < PAR_FACTOR - 1; i++) begin
          m_data[i] <= (IDX_W'(i) < idx) ? stage[i] : '0;
        end
        m_data[PAR_FACTOR-1] <= '0;
        m_count <= CNT_W'(idx);
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
